ext_link_rx: RTL and testbench
==============================

EXT_LINK_RX -- requirements
Module: ext_link_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clocks per serial bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Parameter ACK_CYCLES, default 16, clocks ack_out stays high per accepted frame; legal range 1..255.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 receiver_en  input  1  level enable; low aborts and holds receiver idle.
REQ-006 ext_data_in  input  1  asynchronous serial line, idle high.
REQ-007 ack_out  output  1  frame-accepted handshake back to the remote transmitter.
REQ-008 rx_data  output  8  last accepted byte.
REQ-009 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-010 rx_ready  input  1  consumer takes the byte when rx_valid and rx_ready are both high.
REQ-011 rx_state  output  3  current FSM state encoding, for LED/7-segment debug.
REQ-012 frame_err  output  1  one-clock pulse on a rejected frame.

Function
REQ-013 ext_data_in shall pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-014 FSM states and encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, ACK=5; codes 6-7 unreachable and shall return to IDLE.
REQ-015 IDLE -> START on a synchronized high-to-low transition while receiver_en=1; the bit counter clears.
REQ-016 START: after CLKS_PER_BIT/2 clocks (integer division), line low -> DATA; line high -> IDLE (glitch), with no frame_err.
REQ-017 DATA: sample every CLKS_PER_BIT clocks, LSB first, into an 8-bit shift register; after the 8th sample -> PARITY if compiled in, else STOP.
REQ-018 STOP: sample after CLKS_PER_BIT clocks; line high and output buffer free -> load rx_data, set rx_valid, go to ACK.
REQ-019 STOP: a low stop bit, a parity mismatch, or a full buffer (overrun) shall pulse frame_err for 1 clock, discard the byte, leave rx_data/rx_valid unchanged, raise no ack, and return to IDLE.
REQ-020 "Buffer free" means rx_valid=0, or rx_valid=1 and rx_ready=1 in the same clock; a simultaneous consume and load leaves rx_valid=1 with the new byte.
REQ-021 ACK: ack_out is registered high for exactly ACK_CYCLES clocks, then the FSM goes to IDLE; ack_out is low in every other state.
REQ-022 rx_valid clears the clock after rx_valid&rx_ready when no load coincides; rx_data is stable while rx_valid=1.
REQ-023 receiver_en=0 in any state shall force IDLE on the next clock and drop ack_out; the output buffer is retained and still drains via rx_ready.
REQ-024 Latency: rx_valid rises one clock after the stop-bit sample; ack_out rises in the same clock.

Reset
REQ-025 On reset: state=IDLE, ack_out=0, rx_data=8'h00, rx_valid=0, frame_err=0, counters=0, synchronizer flops=1; this takes effect immediately, including mid-frame.

Configuration
REQ-026 With EXT_RX_PARITY_EN defined: PARITY state samples one even-parity bit after DATA; a mismatch is rejected per REQ-019.
REQ-027 Without EXT_RX_PARITY_EN: PARITY state and its logic are absent, DATA -> STOP directly, and code 3 is unreachable.

Structure
REQ-028 Shared package ext_link_pkg holds the state enum/encodings and the idle-line and frame-length constants, so the transmitter side reuses them.
REQ-029 Sub-module ext_rx_bit_timer: loadable down-counter (width clog2(CLKS_PER_BIT)+1) that produces a one-clock expiry pulse; used for the half-bit and full-bit delays.

Verification (CLKS_PER_BIT=4, ACK_CYCLES=3)
REQ-030 Good frame 0xA5, rx_ready held 0 -> rx_data=0xA5, rx_valid=1, ack_out high for exactly 3 clocks, frame_err=0.
REQ-031 Stop bit driven 0 on byte 0x3C -> frame_err pulses once, rx_valid stays 0, ack_out never rises.
REQ-032 Two frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, second frame raises frame_err and no ack; repeat with rx_ready=1 asserted in the stop-sample clock -> rx_data=0x22, rx_valid=1.
REQ-033 Line low for 1 clock only -> FSM returns to IDLE from START, no frame_err, no ack.
REQ-034 Reset asserted mid-DATA, then receiver_en dropped mid-frame in a second run -> all outputs take reset values immediately (reset) / FSM in IDLE next clock with buffer retained (enable).
REQ-035 With EXT_RX_PARITY_EN, byte 0x07 with parity bit 0 -> frame_err; parity bit 1 -> accepted, rx_data=0x07.

Source files
------------

// File: rtl/ext_link_pkg.sv
// Shared definitions for the external serial link (receiver and transmitter).
// Holds the FSM state encodings, idle-line level and frame-length constants.
package ext_link_pkg;

    localparam int unsigned STATE_W         = 3;
    localparam int unsigned FRAME_DATA_BITS = 8;
    localparam logic        LINE_IDLE       = 1'b1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_ACK    = 3'd5
    } rx_state_e;

    // Even-parity bit that makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ext_rx_bit_timer.sv
// Loadable down-counter used for half-bit and full-bit delays.
// Ports: clk, reset (async high), load/load_val (restart the count),
//        expire_c (combinational, high for the one clock where count == 1,
//        so an action taken on it lands exactly load_val clocks after loading).
module ext_rx_bit_timer #(
    parameter int unsigned CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire_c
);

    logic [CNT_W-1:0] cnt;

    // Count down to zero and park there until reloaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/ext_link_rx.sv
// External serial link receiver: 8N1 (optionally 8E1) frame capture with a
// one-entry output buffer and an ack pulse back to the remote transmitter.
// Optional feature macro: EXT_RX_PARITY_EN (adds an even-parity bit after DATA).
// Ports: clk, reset (async high), receiver_en (level enable),
//        ext_data_in (async serial line, idle high), ack_out (frame accepted),
//        rx_data/rx_valid/rx_ready (output byte handshake),
//        rx_state (FSM code for debug), frame_err (one-clock reject pulse).
module ext_link_rx #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned ACK_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       receiver_en,
    input  logic       ext_data_in,
    output logic       ack_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] rx_state,
    output logic       frame_err
);
    import ext_link_pkg::*;

    localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [7:0]       ACK_LOAD = 8'(ACK_CYCLES);

    rx_state_e        state, state_nxt;
    logic             sync1, sync2, line_prev;
    logic [7:0]       shreg, shreg_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       ack_cnt, ack_cnt_nxt;
    logic             timer_load, bit_tick;
    logic [CNT_W-1:0] timer_val;
    logic             load_buf, frame_err_nxt, buf_free, line, fall, par_ok;

    assign line     = sync2;
    assign fall     = line_prev & ~line;
    assign buf_free = ~rx_valid | rx_ready;
    assign rx_state = state;

`ifdef EXT_RX_PARITY_EN
    logic par_err, par_err_nxt;
    assign par_ok = ~par_err;
`else
    assign par_ok = 1'b1;
`endif

    ext_rx_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expire_c (bit_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and datapath control.
    always_comb begin
        state_nxt     = state;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        ack_cnt_nxt   = ack_cnt;
        timer_load    = 1'b0;
        timer_val     = FULL_BIT;
        load_buf      = 1'b0;
        frame_err_nxt = 1'b0;
`ifdef EXT_RX_PARITY_EN
        par_err_nxt   = par_err;
`endif
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_nxt   = ST_START;
                    bit_cnt_nxt = 3'd0;
                    timer_load  = 1'b1;
                    timer_val   = HALF_BIT;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects short glitches silently.
                if (bit_tick) begin
                    if (line == LINE_IDLE) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt  = ST_DATA;
                        timer_load = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shreg_nxt   = {line, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    timer_load  = 1'b1;
                    if (bit_cnt == 3'(FRAME_DATA_BITS - 1)) begin
`ifdef EXT_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef EXT_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    par_err_nxt = (even_parity(shreg) != line);
                    timer_load  = 1'b1;
                    state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    if (line && par_ok && buf_free) begin
                        load_buf    = 1'b1;
                        ack_cnt_nxt = ACK_LOAD;
                        state_nxt   = ST_ACK;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_IDLE;
                    end
                end
            end
            ST_ACK: begin
                ack_cnt_nxt = ack_cnt - 8'd1;
                if (ack_cnt <= 8'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Disable overrides everything except the output buffer drain.
        if (!receiver_en) begin
            state_nxt     = ST_IDLE;
            load_buf      = 1'b0;
            frame_err_nxt = 1'b0;
        end
    end

    // Synchronizer, shift register, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= LINE_IDLE;
            sync2     <= LINE_IDLE;
            line_prev <= LINE_IDLE;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            ack_cnt   <= 8'd0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            ack_out   <= 1'b0;
            frame_err <= 1'b0;
`ifdef EXT_RX_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else begin
            sync1     <= ext_data_in;
            sync2     <= sync1;
            line_prev <= sync2;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ack_cnt   <= ack_cnt_nxt;
            ack_out   <= (state_nxt == ST_ACK);
            frame_err <= frame_err_nxt;
`ifdef EXT_RX_PARITY_EN
            par_err   <= par_err_nxt;
`endif
            // A load in the same clock as a consume keeps rx_valid high.
            if (load_buf) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ext_link_rx.sv
// Self-checking bench for ext_link_rx (CLKS_PER_BIT=4, ACK_CYCLES=3).
// A frame-level model predicts buffer contents, ack and frame_err per cycle.
module tb_ext_link_rx;

    localparam int unsigned CPB  = 4;
    localparam int unsigned ACKC = 3;
    localparam int unsigned HALF = CPB / 2;
`ifdef EXT_RX_PARITY_EN
    localparam int unsigned PBITS = 1;
`else
    localparam int unsigned PBITS = 0;
`endif
    // Start-edge to stop-decision edge: 2 sync flops, half bit, 8 data bits,
    // optional parity bit, one stop bit.
    localparam int unsigned LAT = 2 + HALF + 9 * CPB + PBITS * CPB;

    logic       clk, reset, receiver_en, ext_data_in, rx_ready;
    logic       ack_out, rx_valid, frame_err;
    logic [7:0] rx_data;
    logic [2:0] rx_state;

    ext_link_rx #(.CLKS_PER_BIT(CPB), .ACK_CYCLES(ACKC)) dut (
        .clk         (clk),
        .reset       (reset),
        .receiver_en (receiver_en),
        .ext_data_in (ext_data_in),
        .ack_out     (ack_out),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_state    (rx_state),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    bit         exp_valid;
    logic [7:0] exp_data;
    int         ack_rem;
    bit         exp_ferr;
    bit         pending;
    int         cd;
    bit         fr_good;
    logic [7:0] fr_byte;
    bit         m_ferr, m_decide;

    int ready_mode;   // 0 hold low, 1 hold high, 2 random, 3 high only at decision edge
    int ack_seen, ferr_seen;
    bit chk_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model.
    initial begin
        exp_valid = 0; exp_data = 8'h00; ack_rem = 0; exp_ferr = 0; pending = 0; cd = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_valid = 0; exp_data = 8'h00; ack_rem = 0; exp_ferr = 0; pending = 0;
            end else begin
                m_ferr = 0;
                m_decide = 0;
                if (ack_rem > 0) ack_rem--;
                if (!receiver_en) begin
                    pending = 0;
                    ack_rem = 0;
                end
                if (pending) begin
                    cd--;
                    if (cd == 0) begin
                        pending = 0;
                        m_decide = 1;
                    end
                end
                if (m_decide) begin
                    if (fr_good && (!exp_valid || rx_ready)) begin
                        exp_data  = fr_byte;
                        exp_valid = 1;
                        ack_rem   = ACKC;
                    end else begin
                        m_ferr = 1;
                    end
                end else if (exp_valid && rx_ready) begin
                    exp_valid = 0;
                end
                exp_ferr = m_ferr;
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        ack_seen = 0; ferr_seen = 0;
        forever begin
            @(negedge clk);
            if (chk_en && !reset) begin
                check("rx_valid", 32'(rx_valid), 32'(exp_valid));
                check("rx_data", 32'(rx_data), 32'(exp_data));
                check("ack_out", 32'(ack_out), 32'(ack_rem > 0));
                check("frame_err", 32'(frame_err), 32'(exp_ferr));
                if (ack_out) ack_seen++;
                if (frame_err) ferr_seen++;
            end
        end
    end

    // Consumer side.
    initial begin
        rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                2:       rx_ready = 1'($urandom_range(0, 1));
                default: rx_ready = (pending && cd == 1);
            endcase
        end
    end

    // Drive one frame; abort_bits>0 stops after that many bit periods.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit pf, input int abort_bits);
        logic [10:0] vec;
        vec = '1;
        vec[0] = 1'b0;
        vec[8:1] = d;
`ifdef EXT_RX_PARITY_EN
        vec[9]  = (^d) ^ pf;
        vec[10] = stop;
`else
        vec[9]  = stop;
`endif
        @(negedge clk);
        for (int i = 0; i < int'(10 + PBITS); i++) begin
            if (abort_bits != 0 && i == abort_bits) return;
            ext_data_in = vec[i];
            if (i == 0) begin
                fr_byte = d;
                fr_good = stop && !pf;
                cd      = LAT + 1;
                pending = 1;
            end
            repeat (CPB) @(negedge clk);
        end
        ext_data_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic drain();
        @(negedge clk);
        #1 ready_mode = 1;
        repeat (3) @(negedge clk);
        #1 check("drain_valid", 32'(rx_valid), 32'd0);
        ready_mode = 0;
    endtask

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1; receiver_en = 1'b1; ext_data_in = 1'b1; ready_mode = 0; chk_en = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", 32'(rx_state), 32'd0);
        check("rst_ack", 32'(ack_out), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_data", 32'(rx_data), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1;
        repeat (4) @(negedge clk);

        // Good frame, consumer stalled
        ack_seen = 0; ferr_seen = 0;
        send_frame(8'hA5, 1, 0, 0);
        #1;
        check("a5_data", 32'(rx_data), 32'hA5);
        check("a5_valid", 32'(rx_valid), 32'd1);
        check("a5_ack_cycles", 32'(ack_seen), 32'd3);
        check("a5_ferr_cnt", 32'(ferr_seen), 32'd0);
        drain();

        // Low stop bit
        ack_seen = 0; ferr_seen = 0;
        send_frame(8'h3C, 0, 0, 0);
        #1;
        check("stop0_ferr_cnt", 32'(ferr_seen), 32'd1);
        check("stop0_valid", 32'(rx_valid), 32'd0);
        check("stop0_ack_cycles", 32'(ack_seen), 32'd0);

        // Overrun, then consume coinciding with load
        ack_seen = 0; ferr_seen = 0;
        send_frame(8'h11, 1, 0, 0);
        send_frame(8'h22, 1, 0, 0);
        #1;
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_ferr_cnt", 32'(ferr_seen), 32'd1);
        check("ovr_ack_cycles", 32'(ack_seen), 32'd3);
        ack_seen = 0; ready_mode = 3;
        send_frame(8'h22, 1, 0, 0);
        #1;
        check("swap_data", 32'(rx_data), 32'h22);
        check("swap_valid", 32'(rx_valid), 32'd1);
        check("swap_ack_cycles", 32'(ack_seen), 32'd3);
        ready_mode = 0;
        drain();

        // One-clock glitch
        ack_seen = 0; ferr_seen = 0;
        @(negedge clk) ext_data_in = 1'b0;
        @(negedge clk) ext_data_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 check("glitch_start", 32'(rx_state), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 check("glitch_idle", 32'(rx_state), 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check("glitch_ferr_cnt", 32'(ferr_seen), 32'd0);
        check("glitch_ack_cycles", 32'(ack_seen), 32'd0);

`ifdef EXT_RX_PARITY_EN
        // Parity reject and accept
        ack_seen = 0; ferr_seen = 0;
        send_frame(8'h07, 1, 1, 0);
        #1;
        check("par0_ferr_cnt", 32'(ferr_seen), 32'd1);
        check("par0_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h07, 1, 0, 0);
        #1;
        check("par1_data", 32'(rx_data), 32'h07);
        check("par1_valid", 32'(rx_valid), 32'd1);
        drain();
`endif

        // Reset mid-DATA clears the buffer immediately
        send_frame(8'h77, 1, 0, 0);
        send_frame(8'h5A, 1, 0, 4);
        #1 check("mid_data_state", 32'(rx_state), 32'd2);
        #1;
        reset = 1'b1;
        ext_data_in = 1'b1;
        #1;
        check("midrst_state", 32'(rx_state), 32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_data", 32'(rx_data), 32'h00);
        check("midrst_ack", 32'(ack_out), 32'd0);
        check("midrst_ferr", 32'(frame_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Enable drop mid-frame keeps the buffer
        send_frame(8'h66, 1, 0, 0);
        send_frame(8'h99, 1, 0, 5);
        receiver_en = 1'b0;
        ext_data_in = 1'b1;
        @(negedge clk);
        #1;
        check("en_state", 32'(rx_state), 32'd0);
        check("en_valid", 32'(rx_valid), 32'd1);
        check("en_data", 32'(rx_data), 32'h66);
        repeat (3 * CPB) @(negedge clk);
        receiver_en = 1'b1;
        drain();

        // Randomized frames with random consumer
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit         stop, pf;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 7) != 0);
            pf   = (PBITS != 0) && ($urandom_range(0, 7) == 0);
            send_frame(d, stop, pf, 0);
        end
        ready_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
